// File: rtl/aeolus_sequencer.sv
// aeolus_sequencer: multi-cycle fetch/decode/execute/writeback controller.
// Owns the PC and IR, resolves SNZA/SNZS squashes, and issues one-hot strobes.
module aeolus_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int PROG_LEN     = 256,
    parameter bit HALT_ON_WRAP = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [3:0]            rom_data,
    input  logic                  shift_flag,
    input  logic                  alu_ovf,
    output logic [15:0]           ctrl_strobe,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  instr_done,
    output logic                  squashed,
    output logic                  wrap,
    output logic                  ovf_sticky,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_SNZA = 4'd8;
    localparam logic [3:0] OP_SNZS = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [3:0]            ir_q;
    logic                  sq_q;
    logic                  sq_d;
    logic                  armed_q;
    logic                  is_last;
    logic [15:0]           strobe_q;
    logic [15:0]           strobe_d;
    logic                  done_q;
    logic                  squashed_q;
    logic                  wrap_q;
    logic                  ovf_q;
    logic                  halted_q;

    // Next PC, squash decision and strobe pattern from the word being decoded
    always_comb begin
        is_last  = (pc_q == LAST_PC);
        pc_d     = is_last ? '0 : pc_q + PC_ONE;
        sq_d     = ((rom_data == OP_SNZA) || (rom_data == OP_SNZS)) && !shift_flag;
        strobe_d = sq_d ? 16'h0000 : (16'd1 << rom_data);
    end

    // Sequencer FSM with all outputs registered; pulses default low each cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            sq_q       <= 1'b0;
            armed_q    <= 1'b0;
            strobe_q   <= '0;
            done_q     <= 1'b0;
            squashed_q <= 1'b0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            strobe_q   <= '0;
            done_q     <= 1'b0;
            squashed_q <= 1'b0;
            wrap_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run && !halted_q) begin
                        state_q <= S_FETCH;
                    end else if (step) begin
                        state_q  <= S_FETCH;
                        armed_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q     <= rom_data;
                    sq_q     <= sq_d;
                    strobe_q <= strobe_d;
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    if ((ir_q == OP_CLR) && !sq_q) begin
                        ovf_q <= 1'b0;
                    end
                    done_q     <= 1'b1;
                    squashed_q <= sq_q;
                    wrap_q     <= is_last;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    if (!sq_q && ((ir_q == OP_ADD) || (ir_q == OP_SUB)) && alu_ovf) begin
                        ovf_q <= 1'b1;
                    end
                    pc_q <= pc_d;
                    if (is_last && HALT_ON_WRAP) begin
                        halted_q <= 1'b1;
                        armed_q  <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (armed_q || !run) begin
                        armed_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign ctrl_strobe = strobe_q;
    assign busy        = (state_q != S_IDLE);
    assign instr_done  = done_q;
    assign squashed    = squashed_q;
    assign wrap        = wrap_q;
    assign ovf_sticky  = ovf_q;
    assign halted      = halted_q;

endmodule
